// File: rtl/fifo_read_checker_if.sv
// fifo_read_checker_if: FIFO read-port handshake plus checker status bundle.
interface fifo_read_checker_if #(
  parameter int unsigned DW = 24
);
  logic          en;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [DW-1:0] exp_data;
  logic [31:0]   word_cnt;
  logic [15:0]   err_cnt;
  logic          err;
  logic [DW-1:0] first_err_data;
  logic [31:0]   first_err_idx;
  logic          busy;
  logic          done;
  modport master (
    output en, rempty, rdata,
    input  rinc, exp_data, word_cnt, err_cnt, err, first_err_data, first_err_idx, busy, done
  );
  modport slave (
    input  en, rempty, rdata,
    output rinc, exp_data, word_cnt, err_cnt, err, first_err_data, first_err_idx, busy, done
  );
endinterface

// File: rtl/fifo_read_checker.sv
// fifo_read_checker: pops a FIFO and checks words against SEED + k*STEP, with optional pacing.
module fifo_read_checker #(
  parameter int unsigned   DW     = 24,
  parameter logic [DW-1:0] SEED   = '0,
  parameter logic [DW-1:0] STEP   = DW'(1),
  parameter int unsigned   NWORDS = 0,
  parameter int unsigned   PACE   = 0,
  parameter bit            RLAT   = 1'b1
) (
  input logic               CLK,
  input logic               RSTn,
  fifo_read_checker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_e;
  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [7:0]    gap_q, gap_d;
  logic [31:0]   iss_q, iss_d, wc_q, wc_d, fidx_q, fidx_d;
  logic [15:0]   ec_q, ec_d;
  logic          err_q, err_d;
  logic [DW-1:0] exp_q, exp_d, fdat_q, fdat_d;
  logic          pop, cmp, last, hit;
  assign pop  = state_q == RUN && bus.en && !bus.rempty;
  assign cmp  = RLAT ? pend_q : pop;
  // iss_q counts issued reads so the final pop is known before any excess read
  assign last = NWORDS != 0 && iss_q == NWORDS - 1;
  assign hit  = NWORDS != 0 && iss_q == NWORDS;
  always_comb begin
    state_d = state_q;
    pend_d  = RLAT && pop;
    gap_d   = gap_q;
    iss_d   = iss_q + {31'd0, pop};
    wc_d    = wc_q;
    ec_d    = ec_q;
    err_d   = err_q;
    exp_d   = exp_q;
    fdat_d  = fdat_q;
    fidx_d  = fidx_q;
    case (state_q)
      IDLE: if (bus.en) begin
        state_d = RUN;
        iss_d   = '0;
        wc_d    = '0;
        ec_d    = '0;
        err_d   = 1'b0;
        fdat_d  = '0;
        fidx_d  = '0;
        exp_d   = SEED;
      end
      RUN: begin
        gap_d   = 8'(PACE - 1);
        state_d = !bus.en ? DRAIN : !pop ? RUN : last ? DRAIN : PACE != 0 ? GAP : RUN;
      end
      GAP: begin
        gap_d   = gap_q - 8'd1;
        state_d = !bus.en ? DRAIN : gap_q == 8'd0 ? RUN : GAP;
      end
      DRAIN: state_d = hit ? DONE : IDLE;
      DONE: state_d = bus.en ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if (cmp) begin
      wc_d  = wc_q + 32'd1;
      exp_d = exp_q + STEP;
      if (bus.rdata != exp_q) begin
        ec_d  = ec_q + {15'd0, ec_q != 16'hFFFF};
        err_d = 1'b1;
        fdat_d = err_q ? fdat_q : bus.rdata;
        fidx_d = err_q ? fidx_q : wc_q;
      end
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      iss_q   <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
      err_q   <= 1'b0;
      exp_q   <= SEED;
      fdat_q  <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      iss_q   <= iss_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      fdat_q  <= fdat_d;
      fidx_q  <= fidx_d;
    end
  end
  assign bus.rinc           = pop;
  assign bus.exp_data       = exp_q;
  assign bus.word_cnt       = wc_q;
  assign bus.err_cnt        = ec_q;
  assign bus.err            = err_q;
  assign bus.first_err_data = fdat_q;
  assign bus.first_err_idx  = fidx_q;
  assign bus.busy           = state_q == RUN || state_q == GAP || state_q == DRAIN;
  assign bus.done           = state_q == DONE;
endmodule

// File: tb/tb_fifo_read_checker.sv
// tb_fifo_read_checker: three checker instances (RLAT=1 bounded, RLAT=0 wrap, paced free-run) on FIFO models.
module tb_fifo_read_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fifo_read_checker_if #(.DW(24)) ia();
  fifo_read_checker_if #(.DW(24)) ib();
  fifo_read_checker_if #(.DW(24)) ic();
  fifo_read_checker #(.DW(24), .SEED(24'h000000), .STEP(24'h1), .NWORDS(16), .PACE(0), .RLAT(1'b1))
    dut_a (.CLK(clk), .RSTn(rst_n), .bus(ia.slave));
  fifo_read_checker #(.DW(24), .SEED(24'hFFFFFE), .STEP(24'h1), .NWORDS(4), .PACE(0), .RLAT(1'b0))
    dut_b (.CLK(clk), .RSTn(rst_n), .bus(ib.slave));
  fifo_read_checker #(.DW(24), .SEED(24'h000100), .STEP(24'h3), .NWORDS(0), .PACE(2), .RLAT(1'b1))
    dut_c (.CLK(clk), .RSTn(rst_n), .bus(ic.slave));
  logic [23:0] ma [128];
  logic [23:0] mb [128];
  logic [23:0] mc [128];
  int fwa = 0, fra = 0, fwb = 0, frb = 0, fwc = 0, frc = 0;
  logic fec = 1'b0;
  logic [23:0] rda, rdc;
  assign ia.rempty = fra >= fwa;
  assign ib.rempty = frb >= fwb;
  assign ic.rempty = frc >= fwc || fec;
  assign ia.rdata  = rda;
  assign ib.rdata  = mb[frb];
  assign ic.rdata  = rdc;
  always @(posedge clk) begin
    if (ia.rinc) begin
      rda <= ma[fra];
      fra <= fra + 1;
    end
    if (ib.rinc) frb <= frb + 1;
    if (ic.rinc) begin
      rdc <= mc[frc];
      frc <= frc + 1;
    end
  end
  int viol = 0, pops_a = 0, pops_b = 0, pops_c = 0, cyc = 0, last_c = -1, mingap_c = 1000;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ((ia.rinc && ia.rempty) || (ib.rinc && ib.rempty) || (ic.rinc && ic.rempty)) viol <= viol + 1;
    if (ia.rinc) pops_a <= pops_a + 1;
    if (ib.rinc) pops_b <= pops_b + 1;
    if (ic.rinc) begin
      pops_c <= pops_c + 1;
      if (last_c >= 0 && cyc - last_c < mingap_c) mingap_c <= cyc - last_c;
      last_c <= cyc;
    end
  end
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic [23:0] data;
    logic [31:0] wc;
    logic [15:0] ec;
    logic [23:0] exd;
    logic        dn;
  } vec_t;
  vec_t tv [16];
  task automatic load_a();
    fwa = fra;
    for (int k = 0; k < 16; k++) begin
      ma[fwa] = tv[k].data;
      fwa++;
    end
  endtask
  initial begin
    int t, n;
    logic [31:0] prev;
    ia.en = 1'b0;
    ib.en = 1'b0;
    ic.en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tv[k].data = (k == 5) ? 24'h000099 : 24'(k);
      tv[k].wc   = 32'(k + 1);
      tv[k].ec   = (k >= 5) ? 16'd1 : 16'd0;
      tv[k].exd  = 24'(k + 1);
      tv[k].dn   = (k == 15);
    end
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rinc", ia.rinc, 0);
    chk("rst_exp_a", ia.exp_data, 24'h000000);
    chk("rst_exp_c", ic.exp_data, 24'h000100);
    chk("rst_wc", ia.word_cnt, 0);
    chk("rst_busy_done", {ia.busy, ia.done}, 0);
    @(negedge clk) rst_n = 1'b1;
    // clean-plus-one-error stream on A, 4 spare words to catch any 17th read
    load_a();
    for (int k = 0; k < 4; k++) begin
      ma[fwa] = 24'(16 + k);
      fwa++;
    end
    ia.en = 1'b1;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      t = 0;
      while (ia.word_cnt == prev && t < 20) begin
        @(negedge clk);
        t++;
      end
      prev = ia.word_cnt;
      chk($sformatf("a_wc[%0d]", k), ia.word_cnt, tv[k].wc);
      chk($sformatf("a_ec[%0d]", k), ia.err_cnt, tv[k].ec);
      chk($sformatf("a_exp[%0d]", k), ia.exp_data, tv[k].exd);
      chk($sformatf("a_done[%0d]", k), ia.done, tv[k].dn);
    end
    chk("a_busy_at_done", ia.busy, 0);
    chk("a_first_data", ia.first_err_data, 24'h000099);
    chk("a_first_idx", ia.first_err_idx, 5);
    chk("a_err", ia.err, 1);
    repeat (5) @(negedge clk);
    chk("a_pops", pops_a, 16);
    chk("a_done_hold", {ia.done, ia.word_cnt}, {1'b1, 32'd16});
    ia.en = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_done_clr", ia.done, 0);
    // early stop after 7 pops
    load_a();
    ia.en = 1'b1;
    n = 0;
    t = 0;
    while (n < 7 && t < 50) begin
      @(negedge clk);
      t++;
      if (ia.rinc) n++;
    end
    @(posedge clk);
    #1 ia.en = 1'b0;
    t = 0;
    while (ia.busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("stop_busy", ia.busy, 0);
    chk("stop_wc", ia.word_cnt, 7);
    chk("stop_done", ia.done, 0);
    chk("stop_pops", pops_a, 23);
    chk("stop_ec", ia.err_cnt, 1);
    chk("stop_first_idx", ia.first_err_idx, 5);
    load_a();
    ia.en = 1'b1;
    @(negedge clk);
    chk("restart_wc", ia.word_cnt, 0);
    chk("restart_exp", ia.exp_data, 24'h000000);
    chk("restart_err", {ia.err, ia.err_cnt}, 0);
    t = 0;
    while (ia.word_cnt != 3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("restart_wc3", ia.word_cnt, 3);
    chk("restart_exp3", ia.exp_data, 24'h000003);
    chk("restart_err3", ia.err, 0);
    ia.en = 1'b0;
    // RLAT=0 wrap on B
    mb[0] = 24'hFFFFFE;
    mb[1] = 24'hFFFFFF;
    mb[2] = 24'h000000;
    mb[3] = 24'h000001;
    mb[4] = 24'h000002;
    mb[5] = 24'h000003;
    fwb = 6;
    ib.en = 1'b1;
    t = 0;
    while (ib.word_cnt != 4 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("b_wc", ib.word_cnt, 4);
    chk("b_done_lag", ib.done, 0);
    @(negedge clk);
    chk("b_done", ib.done, 1);
    chk("b_ec", {ib.err, ib.err_cnt}, 0);
    chk("b_exp", ib.exp_data, 24'h000002);
    repeat (3) @(negedge clk);
    chk("b_pops", pops_b, 4);
    ib.en = 1'b0;
    // paced free-run on C with random empty gating
    for (int k = 0; k < 32; k++) mc[k] = 24'h000100 + 24'(3 * k);
    fwc = 32;
    ic.en = 1'b1;
    t = 0;
    while (ic.word_cnt < 20 && t < 500) begin
      @(posedge clk);
      #1 fec = ($urandom_range(0, 2) == 0);
      t++;
    end
    chk("c_wc", ic.word_cnt, 20);
    chk("c_exp", ic.exp_data, 24'h00013C);
    chk("c_ec", {ic.err, ic.err_cnt}, 0);
    chk("c_min_gap_ok", mingap_c >= 3, 1);
    chk("c_viol", viol, 0);
    // asynchronous reset while C is popping
    fec = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ic.rinc && t < 20);
    chk("c_rinc_before_rst", ic.rinc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rinc", ic.rinc, 0);
    chk("ar_exp", ic.exp_data, 24'h000100);
    chk("ar_wc", ic.word_cnt, 0);
    chk("ar_err", {ic.err, ic.err_cnt}, 0);
    chk("ar_busy_done", {ic.busy, ic.done}, 0);
    chk("ar_a_wc", ia.word_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_read_checker.md
# fifo_read_checker

Read-side traffic consumer for the 24-bit FIFO test harness, on the opposite end of the FIFO from the write-side generator. It pops words whenever the FIFO reports non-empty and compares each word against a locally generated expected sequence (SEED, SEED+STEP, …). It reports word count, error count and the first mismatch, and optionally paces its reads to exercise FIFO back-pressure. It runs in the same clock domain as the FIFO read port.

## Interface
- DW, 24: data width.
- SEED, 0: first expected word.
- STEP, 1: expected-value increment, modulo 2^DW.
- NWORDS, 0: compares before done; 0 = run forever.
- PACE, 0: idle cycles inserted after each pop (0..255).
- RLAT, 1: FIFO read latency; 0 = head word valid on rdata while rempty=0, 1 = rdata valid the cycle after rinc.

- CLK  in  1  clock.
- RSTn  in  1  one clock; reset is asynchronous and active-low.
- en  in  1  run enable.
- rempty  in  1  FIFO empty flag.
- rdata  in  DW  FIFO read data.
- rinc  out  1  FIFO pop request.
- exp_data  out  DW  next expected word.
- word_cnt  out  32  compares performed.
- err_cnt  out  16  mismatches, saturating at 16'hFFFF.
- err  out  1  sticky mismatch flag.
- first_err_data  out  DW  rdata of the first mismatch.
- first_err_idx  out  32  word_cnt value at the first mismatch.
- busy  out  1  state is RUN, GAP or DRAIN.
- done  out  1  NWORDS compares completed.

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE.
- Reset (async, RSTn=0): state=IDLE; exp_data=SEED; all counters, err, first_err_*, busy and done = 0. rinc=0 while RSTn=0.
- IDLE: rinc=0. When en=1, go to RUN. On this transition, clear word_cnt, err_cnt, err and first_err_*, and load exp_data=SEED.
- RUN: rinc = !rempty (combinational; never asserted while rempty=1). Next state depends on the pop:
  - Pop that issues read number NWORDS (NWORDS≠0): go to DRAIN.
  - Pop with PACE>0: go to GAP.
  - No pop: stay in RUN.
  - en=0: go to DRAIN; no further pops.
- GAP: rinc=0 for exactly PACE cycles, then return to RUN, or go to DRAIN if en=0.
- DRAIN: wait for the outstanding compare. With RLAT=1 this takes 1 cycle; with RLAT=0 it takes 0 cycles, i.e. a pass-through cycle with nothing pending. Then go to DONE if the NWORDS target was reached, otherwise go to IDLE.
- DONE: done=1 and rinc=0. Stay in DONE until en=0, then go to IDLE. Counters are retained.
- Compare point:
  - RLAT=0: the cycle rinc=1, using rdata in that cycle.
  - RLAT=1: the cycle after rinc=1, via a 1-bit registered valid.
- At each compare:
  - word_cnt += 1.
  - exp_data += STEP, modulo 2^DW. No resync to the received value.
  - On rdata≠exp_data: err_cnt += 1 (saturating), err ← 1. If err was 0, capture first_err_data=rdata and first_err_idx=word_cnt (the pre-increment value).
- Issued pops are counted separately (32-bit) so that NWORDS stops pops before excess reads; word_cnt equals NWORDS exactly at done.

## Timing
- rinc is combinational from state and rempty. All other outputs are registered and update on the CLK edge ending the compare cycle.
- Throughput: 1 pop/cycle at PACE=0; 1 pop per (PACE+1) cycles otherwise.
- done rises on the edge after the last compare (DRAIN→DONE). busy falls in the same cycle.
- en=0 mid-RUN: no pop in the cycle en is sampled low. A pending RLAT=1 compare still completes.
- Async reset mid-run: rinc drops immediately. A pending compare is discarded.
- word_cnt wraps at 2^32 when NWORDS=0. err_cnt holds at 16'hFFFF.

## Test plan
- Reset: assert RSTn=0 mid-stream -> rinc=0 immediately; exp_data=SEED, counters=0, err=0, done=0.
- Clean stream, RLAT=1, NWORDS=16: FIFO loaded with 0..15 -> 16 pops, word_cnt=16, err_cnt=0, done=1 one cycle after the last compare, no 17th rinc.
- Single error: word 5 replaced with 24'h000099 -> err_cnt=1, err=1, first_err_data=24'h000099, first_err_idx=5, word 6 compares clean (exp_data continued).
- Empty gating and pacing, PACE=2: rempty toggled randomly -> rinc never high while rempty=1, pops ≥3 cycles apart, data intact.
- Wrap: SEED=24'hFFFFFE, NWORDS=4, RLAT=0 -> expected FFFFFE, FFFFFF, 000000, 000001; err_cnt=0.
- Early stop: en=0 after 7 pops with RLAT=1 -> no further rinc, word_cnt=7, return to IDLE with done=0; en=1 again clears counters and restarts at SEED.
